// File: rtl/conv_mem_loader_if.sv
// Stream-in / BRAM-write bundle for the convolution memory loader.
// The loader uses the slave side; the byte source and the memory port model use the master side.
interface conv_mem_loader_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 17
);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dia;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  wea,
    input  addra,
    input  dia
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output wea,
    output addra,
    output dia
  );
endinterface

// File: rtl/conv_mem_loader.sv
// Streams image bytes into BRAM replicated 'copies' times at (c<<11)+j.
// It then streams filter taps tap-reversed into the 0x10000 region at (f<<6)+(taps-1-t).
module conv_mem_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [10:0]        img_words_i,
  input  logic [4:0]         copies_i,
  input  logic [3:0]         n_filters_i,
  input  logic [5:0]         taps_i,
  conv_mem_loader_if.slave   bus,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {StIdle, StImgLoad, StImgRep, StFlt, StDone} state_e;

  state_e                state_q;
  logic [10:0]           img_words_q;
  logic [4:0]            copies_q;
  logic [3:0]            n_filters_q;
  logic [5:0]            taps_q;
  logic [10:0]           pix_q;
  logic [4:0]            copy_q;
  logic [3:0]            filt_q;
  logic [5:0]            tap_q;
  logic [DATA_WIDTH-1:0] byte_q;

  logic       hs;
  logic       flt_empty;
  logic [4:0] copy_inc;
  logic [5:0] tap_rev;

  // Gated by rst so the source never sees a handshake while reset is applied.
  assign bus.s_ready = !rst && ((state_q == StImgLoad) || (state_q == StFlt));
  assign hs          = bus.s_valid && bus.s_ready;
  assign flt_empty   = (n_filters_q == 4'd0) || (taps_q == 6'd0);
  assign copy_inc    = copy_q + 5'd1;
  assign tap_rev     = taps_q - 6'd1 - tap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      img_words_q <= '0;
      copies_q    <= '0;
      n_filters_q <= '0;
      taps_q      <= '0;
      pix_q       <= '0;
      copy_q      <= '0;
      filt_q      <= '0;
      tap_q       <= '0;
      byte_q      <= '0;
      bus.wea     <= 1'b0;
      bus.addra   <= '0;
      bus.dia     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      bus.wea <= 1'b0;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            img_words_q <= img_words_i;
            copies_q    <= (copies_i == 5'd0) ? 5'd1 : copies_i;
            n_filters_q <= n_filters_i;
            taps_q      <= taps_i;
            pix_q       <= '0;
            copy_q      <= '0;
            filt_q      <= '0;
            tap_q       <= '0;
            busy        <= 1'b1;
            if (img_words_i != 11'd0) begin
              state_q <= StImgLoad;
            end else if ((n_filters_i != 4'd0) && (taps_i != 6'd0)) begin
              state_q <= StFlt;
            end else begin
              state_q <= StDone;
              done    <= 1'b1;
            end
          end
        end
        StImgLoad: begin
          if (hs) begin
            byte_q    <= bus.s_data;
            copy_q    <= '0;
            bus.wea   <= 1'b1;
            bus.addra <= ADDR_WIDTH'({5'd0, pix_q});
            bus.dia   <= bus.s_data;
            state_q   <= StImgRep;
          end
        end
        StImgRep: begin
          if (copy_q != copies_q - 5'd1) begin
            copy_q    <= copy_inc;
            bus.wea   <= 1'b1;
            bus.addra <= ADDR_WIDTH'({copy_inc, pix_q});
            bus.dia   <= byte_q;
          end else begin
            // Last replica was written on the previous edge; this edge is the inter-pixel gap.
            copy_q <= '0;
            if (pix_q == img_words_q - 11'd1) begin
              pix_q <= '0;
              if (flt_empty) begin
                state_q <= StDone;
                done    <= 1'b1;
              end else begin
                state_q <= StFlt;
              end
            end else begin
              pix_q   <= pix_q + 11'd1;
              state_q <= StImgLoad;
            end
          end
        end
        StFlt: begin
          if (hs) begin
            bus.wea   <= 1'b1;
            bus.addra <= ADDR_WIDTH'({1'b1, 6'd0, filt_q, tap_rev});
            bus.dia   <= bus.s_data;
            if (tap_q == taps_q - 6'd1) begin
              tap_q <= '0;
              if (filt_q == n_filters_q - 4'd1) begin
                filt_q  <= '0;
                state_q <= StDone;
                done    <= 1'b1;
              end else begin
                filt_q <= filt_q + 4'd1;
              end
            end else begin
              tap_q <= tap_q + 6'd1;
            end
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/conv_mem_loader.md
CONV_MEM_LOADER -- requirements
Module: conv_mem_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the width of stream and BRAM data.
REQ-002 Parameter ADDR_WIDTH, default 17, sets the width of the BRAM write address.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: single-cycle pulse that launches a load.
REQ-006 Port img_words_i, input, 11 bits: number of image bytes (default use 1024).
REQ-007 Port copies_i, input, 5 bits: number of image replicas (default use 25).
REQ-008 Port n_filters_i, input, 4 bits: number of filters (default use 6).
REQ-009 Port taps_i, input, 6 bits: taps per filter (default use 25).
REQ-010 Port s_valid, input, 1 bit: stream byte valid.
REQ-011 Port s_data, input, DATA_WIDTH bits: stream byte; all image bytes come first, then filters (filter-major, tap 0 first).
REQ-012 Port s_ready, output, 1 bit: loader accepts s_data this cycle.
REQ-013 Port wea, output, 1 bit: BRAM write enable.
REQ-014 Port addra, output, ADDR_WIDTH bits: BRAM write address.
REQ-015 Port dia, output, DATA_WIDTH bits: BRAM write data.
REQ-016 Port busy, output, 1 bit: high from the cycle after start is accepted until the cycle after done.
REQ-017 Port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-018 States SHALL be IDLE, IMG_LOAD, IMG_REP, FLT and DONE.
REQ-019 In IDLE, a start pulse SHALL latch all four config inputs; later config changes SHALL have no effect until the next start.
REQ-020 A start pulse outside IDLE SHALL be ignored.
REQ-021 From IDLE on start, the next state SHALL be IMG_LOAD; if img_words_i is 0 it SHALL be FLT; if n_filters_i or taps_i is also 0 it SHALL be DONE.
REQ-022 copies_i of 0 SHALL be treated as 1.
REQ-023 s_ready SHALL be combinational: 1 only in IMG_LOAD and FLT, 0 in all other states.
REQ-024 A handshake is s_valid and s_ready high at a rising edge; bytes are never dropped or duplicated.
REQ-025 wea, addra and dia SHALL be registered.
REQ-026 wea SHALL be 0 in every cycle not listed in REQ-027 to REQ-030.
REQ-027 On an IMG_LOAD handshake for pixel j, the byte SHALL be held and the state SHALL go to IMG_REP with copy counter c=0; the next cycle SHALL show wea=1, addra=(0<<11)+j, dia=byte.
REQ-028 In IMG_REP, each edge with c<copies-1 SHALL increment c and present addra=(c<<11)+j with the same dia; the image pattern is addra = (c<<11)+j.
REQ-029 In IMG_REP at c=copies-1, the edge SHALL clear wea and go to IMG_LOAD with j+1; if j=img_words-1 it SHALL go to FLT (or DONE if filters are empty). Each pixel therefore takes copies+1 cycles.
REQ-030 Each FLT handshake for filter f, tap t SHALL produce, next cycle, wea=1, addra=(1<<16)+(f<<6)+(taps-1-t), dia=byte (tap-reversed); this gives up to one write per cycle.
REQ-031 After the handshake for f=n_filters-1, t=taps-1, the state SHALL go to DONE.
REQ-032 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-033 Address arithmetic SHALL be unsigned and zero-extended to ADDR_WIDTH; no field overflows at the maximum config.
REQ-034 s_valid while s_ready=0 SHALL be ignored; the source must hold the byte.

Reset
REQ-035 With rst high at an edge, the next state SHALL be IDLE, and wea, addra, dia, busy, done, all counters and the held byte SHALL be 0, including mid-load; partially written memory is not restored.
REQ-036 s_ready SHALL be 0 while in reset.

Verification
REQ-037 Default load: 1024 image bytes, copies=25, 6x25 filters, s_valid always 1 -> 25600 image writes at (c<<11)+j, then 150 filter writes at 0x10000+(f<<6)+(24-t); done at cycle 1024*26+150+2 after start.
REQ-038 Replication timing: img_words=2, copies=3, bytes 0x37,0x93 -> writes 0x37@0x0000,0x0800,0x1000, then idle 1 cycle, then 0x93@0x0001,0x0801,0x1001.
REQ-039 Backpressure/gaps: random s_valid gaps in FLT with 1x4 filter bytes 1,2,3,4 -> exactly 4 writes, dia 4,3,2,1 at 0x10000..0x10003, with no extra wea.
REQ-040 Boundaries: img_words=0 -> first write is a filter; n_filters=0 and img_words=0 -> done the cycle after start with no writes; copies=0 -> one copy per pixel.
REQ-041 Start during busy is ignored; rst asserted mid-IMG_REP -> wea=0 and IDLE next cycle, and a fresh start then reloads correctly from j=0.
